// File: rtl/host_byte_framer_if.sv
// Bundles the byte-link and 64-bit word-side signals of host_byte_framer.
// The master modport is the framer; the slave modport is the host/core side.
interface host_byte_framer_if #(
    parameter int CMD_W = 16
);
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ready;
    logic [CMD_W-1:0] cmd;
    logic             cmd_hasAny;
    logic             cmd_consume;
    logic [63:0]      in;
    logic             in_isReady;
    logic             in_canReceive;
    logic [63:0]      out;
    logic             out_isReady;
    logic             out_canReceive;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready;
    logic             err_badHeader;

    modport master (
        input  rx_byte, rx_valid, cmd_consume, in_canReceive, out, out_isReady, tx_ready,
        output rx_ready, cmd, cmd_hasAny, in, in_isReady, out_canReceive, tx_byte, tx_valid,
               err_badHeader
    );

    modport slave (
        output rx_byte, rx_valid, cmd_consume, in_canReceive, out, out_isReady, tx_ready,
        input  rx_ready, cmd, cmd_hasAny, in, in_isReady, out_canReceive, tx_byte, tx_valid,
               err_badHeader
    );
endinterface

// File: rtl/host_byte_framer.sv
// Byte-serial host bridge: parses host bytes into command and 64-bit data words,
// and serialises 64-bit result words back into bytes, one register per direction.
module host_byte_framer #(
    parameter int CMD_W     = 16,
    parameter int CMD_BYTES = 2
) (
    input logic                clk,
    input logic                rst,
    host_byte_framer_if.master bus
);
    typedef enum logic [1:0] {S_HDR, S_CMD, S_DATA} rx_state_t;

    rx_state_t   state, state_nx;
    logic        rx_ready;
    logic        rx_fire;
    logic        cmd_done;
    logic        word_done;
    logic [63:0] rx_shift;
    logic [63:0] rx_payload;
    logic [2:0]  byte_cnt;
    logic [7:0]  words_left;
    logic [63:0] tx_shift;
    logic [3:0]  tx_cnt;

    // Header 0x80 stalls only while an unconsumed command is still held.
    always_comb begin
        rx_ready = 1'b0;
        unique case (state)
            S_HDR:   rx_ready = !(bus.rx_byte == 8'h80 && bus.cmd_hasAny && !bus.cmd_consume);
            S_CMD:   rx_ready = 1'b1;
            S_DATA:  rx_ready = !bus.in_isReady || bus.in_canReceive;
            default: rx_ready = 1'b0;
        endcase
        if (!rst) rx_ready = 1'b0;
    end

    assign bus.rx_ready = rx_ready;
    assign rx_fire      = rx_ready && bus.rx_valid;
    assign rx_payload   = {rx_shift[55:0], bus.rx_byte};
    assign cmd_done     = rx_fire && (state == S_CMD) && (byte_cnt == 3'(CMD_BYTES - 1));
    assign word_done    = rx_fire && (state == S_DATA) && (byte_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HDR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rx_fire) begin
            unique case (state)
                S_HDR: begin
                    if (!bus.rx_byte[7])           state_nx = S_DATA;
                    else if (bus.rx_byte == 8'h80) state_nx = S_CMD;
                end
                S_CMD:   if (cmd_done) state_nx = S_HDR;
                S_DATA:  if (word_done && words_left == 8'd1) state_nx = S_HDR;
                default: state_nx = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift          <= '0;
            byte_cnt          <= '0;
            words_left        <= '0;
            bus.cmd           <= '0;
            bus.cmd_hasAny    <= 1'b0;
            bus.in            <= '0;
            bus.in_isReady    <= 1'b0;
            bus.err_badHeader <= 1'b0;
        end else begin
            if (rx_fire) begin
                if (state == S_HDR) begin
                    byte_cnt <= '0;
                    if (!bus.rx_byte[7])           words_left <= {1'b0, bus.rx_byte[6:0]} + 8'd1;
                    else if (bus.rx_byte != 8'h80) bus.err_badHeader <= 1'b1;
                end else begin
                    rx_shift <= rx_payload;
                    byte_cnt <= cmd_done ? '0 : byte_cnt + 3'd1;
                end
            end

            if (cmd_done) begin
                bus.cmd        <= rx_payload[CMD_W-1:0];
                bus.cmd_hasAny <= 1'b1;
            end else if (bus.cmd_consume) begin
                bus.cmd_hasAny <= 1'b0;
            end

            // A word completing on the transfer edge wins over the clear.
            if (word_done) begin
                bus.in         <= rx_payload;
                bus.in_isReady <= 1'b1;
                words_left     <= words_left - 8'd1;
            end else if (bus.in_isReady && bus.in_canReceive) begin
                bus.in_isReady <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else if (tx_cnt == 4'd0) begin
            if (bus.out_isReady) begin
                tx_shift <= bus.out;
                tx_cnt   <= 4'd8;
            end
        end else if (bus.tx_ready) begin
            tx_shift <= {tx_shift[55:0], 8'h00};
            tx_cnt   <= tx_cnt - 4'd1;
        end
    end

    assign bus.tx_byte        = tx_shift[63:56];
    assign bus.tx_valid       = (tx_cnt != 4'd0);
    assign bus.out_canReceive = rst && (tx_cnt == 4'd0);
endmodule

// File: tb/tb_host_byte_framer.sv
// Scoreboard bench for host_byte_framer: expected cmd/data words and tx bytes are
// queued at stimulus time and compared by a negedge monitor at each handshake.
module tb_host_byte_framer;
    localparam int CMD_W = 16;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   cmd_p = 0;
    int   in_p  = 0;
    int   tx_p  = 0;
    bit   tx_toggle = 0;
    int   tx_pops = 0;

    logic [CMD_W-1:0] cmd_q[$];
    logic [63:0]      word_q[$];
    logic [7:0]       tx_q[$];

    host_byte_framer_if #(.CMD_W(CMD_W)) bus ();

    host_byte_framer #(.CMD_W(CMD_W), .CMD_BYTES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input logic [63:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %h expected a pending entry", name, act);
    endtask

    // Core/host-side consumers: random acceptance with per-channel probability.
    initial begin
        bus.cmd_consume   = 1'b0;
        bus.in_canReceive = 1'b0;
        bus.tx_ready      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.cmd_consume   = (int'($urandom_range(0, 99)) < cmd_p);
            bus.in_canReceive = (int'($urandom_range(0, 99)) < in_p);
            bus.tx_ready      = tx_toggle ? ~bus.tx_ready : (int'($urandom_range(0, 99)) < tx_p);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.cmd_hasAny && bus.cmd_consume) begin
                if (cmd_q.size() == 0) fail_msg("cmd_unexpected", 64'(bus.cmd));
                else chk("cmd", 64'(bus.cmd), 64'(cmd_q.pop_front()));
            end
            if (bus.in_isReady && bus.in_canReceive) begin
                if (word_q.size() == 0) fail_msg("word_unexpected", bus.in);
                else chk("data_word", bus.in, word_q.pop_front());
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_pops++;
                if (tx_q.size() == 0) fail_msg("tx_unexpected", 64'(bus.tx_byte));
                else chk("tx_byte", 64'(bus.tx_byte), 64'(tx_q.pop_front()));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1 so consecutive calls offer bytes back to back.
    task automatic rx_send(input logic [7:0] b, inout int stalls);
        int t;
        t = 0;
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) break;
            stalls++;
            t++;
            if (t > 300) begin
                fail_msg("rx_timeout", 64'(b));
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, inout int stalls);
        for (int k = 0; k < 8; k++) rx_send(w[63-8*k -: 8], stalls);
    endtask

    task automatic tx_load(input logic [63:0] w);
        int t;
        t = 0;
        for (int k = 0; k < 8; k++) tx_q.push_back(w[63-8*k -: 8]);
        bus.out         = w;
        bus.out_isReady = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.out_canReceive) break;
            t++;
            if (t > 300) begin
                fail_msg("tx_load_timeout", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.out_isReady = 1'b0;
    endtask

    task automatic rand_rx(input int npk);
        int st;
        int kind;
        int nw;
        logic [CMD_W-1:0] v;
        logic [63:0] w;
        st = 0;
        for (int p = 0; p < npk; p++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                v = CMD_W'($urandom);
                cmd_q.push_back(v);
                rx_send(8'h80, st);
                rx_send(v[15:8], st);
                rx_send(v[7:0], st);
            end else if (kind == 3) begin
                rx_send(8'(8'h81 + $urandom_range(0, 126)), st);
            end else begin
                nw = $urandom_range(1, 4);
                rx_send(8'(nw - 1), st);
                for (int i = 0; i < nw; i++) begin
                    w = {$urandom, $urandom};
                    word_q.push_back(w);
                    send_word(w, st);
                end
            end
            repeat ($urandom_range(0, 2)) sync();
        end
    endtask

    task automatic rand_tx(input int n);
        for (int i = 0; i < n; i++) begin
            tx_load({$urandom, $urandom});
            repeat ($urandom_range(0, 10)) sync();
        end
    endtask

    task automatic drain(input string tag);
        cmd_p = 100;
        in_p  = 100;
        tx_p  = 100;
        for (int c = 0; c < 2000; c++) begin
            if (cmd_q.size() == 0 && word_q.size() == 0 && tx_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        chk({tag, "_cmd_left"}, 64'(cmd_q.size()), 64'd0);
        chk({tag, "_word_left"}, 64'(word_q.size()), 64'd0);
        chk({tag, "_tx_left"}, 64'(tx_q.size()), 64'd0);
        sync();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        chk({tag, "_cmd"}, 64'(bus.cmd), 64'd0);
        chk({tag, "_cmd_hasAny"}, 64'(bus.cmd_hasAny), 64'd0);
        chk({tag, "_in"}, bus.in, 64'd0);
        chk({tag, "_in_isReady"}, 64'(bus.in_isReady), 64'd0);
        chk({tag, "_out_canReceive"}, 64'(bus.out_canReceive), 64'd0);
        chk({tag, "_tx_byte"}, 64'(bus.tx_byte), 64'd0);
        chk({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
        chk({tag, "_err"}, 64'(bus.err_badHeader), 64'd0);
    endtask

    initial begin
        int st;
        int t;
        int base;
        logic [63:0] w;

        rst             = 1'b0;
        bus.rx_byte     = '0;
        bus.rx_valid    = 1'b0;
        bus.out         = '0;
        bus.out_isReady = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sync();

        // Command held without consume; next 0x80 header must stall.
        cmd_p = 0;
        st = 0;
        cmd_q.push_back(16'h1234);
        rx_send(8'h80, st);
        rx_send(8'h12, st);
        rx_send(8'h34, st);
        repeat (5) begin
            @(negedge clk);
            chk("t1_hasAny_held", 64'(bus.cmd_hasAny), 64'd1);
            chk("t1_cmd_held", 64'(bus.cmd), 64'h1234);
        end
        sync();
        fork
            begin
                cmd_q.push_back(16'hABCD);
                rx_send(8'h80, st);
                rx_send(8'hAB, st);
                rx_send(8'hCD, st);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("t1_hdr_stall", 64'(bus.rx_ready), 64'd0);
                end
                cmd_p = 100;
            end
        join

        // Reserved header sets the sticky error; a following command still parses.
        chk("t5_err_before", 64'(bus.err_badHeader), 64'd0);
        rx_send(8'h9A, st);
        chk("t5_err_set", 64'(bus.err_badHeader), 64'd1);
        cmd_q.push_back(16'h0005);
        rx_send(8'h80, st);
        rx_send(8'h00, st);
        rx_send(8'h05, st);

        // Two-word packet with the core always accepting: no RX stall.
        in_p = 100;
        sync();
        st = 0;
        word_q.push_back(64'h0102030405060708);
        word_q.push_back(64'h1112131415161718);
        rx_send(8'h01, st);
        send_word(64'h0102030405060708, st);
        send_word(64'h1112131415161718, st);
        chk("t2_no_stall", 64'(st), 64'd0);

        // Same packet with the core refusing for 10 cycles after word 1.
        in_p = 0;
        repeat (3) sync();
        st = 0;
        word_q.push_back(64'h0102030405060708);
        word_q.push_back(64'h1112131415161718);
        fork
            begin
                rx_send(8'h01, st);
                send_word(64'h0102030405060708, st);
                send_word(64'h1112131415161718, st);
            end
            begin
                t = 0;
                forever begin
                    @(negedge clk);
                    if (bus.in_isReady || t > 100) break;
                    t++;
                end
                repeat (10) begin
                    chk("t3_word1_held", bus.in, 64'h0102030405060708);
                    @(negedge clk);
                end
                in_p = 100;
            end
        join
        chk("t3_stall_seen", 64'(st >= 8), 64'd1);
        drain("t3");

        // TX with tx_ready toggling; out_canReceive low until the last byte leaves.
        tx_toggle = 1'b1;
        tx_load(64'hDEADBEEF01234567);
        #1;
        for (int c = 0; c < 40; c++) begin
            chk("t4_out_canReceive", 64'(bus.out_canReceive), 64'(tx_q.size() == 0));
            if (tx_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        tx_toggle = 1'b0;
        sync();

        // Randomised concurrent RX and TX traffic.
        cmd_p = 50;
        in_p  = 60;
        tx_p  = 60;
        fork
            rand_rx(30);
            rand_tx(15);
        join
        drain("rand");
        chk("err_sticky", 64'(bus.err_badHeader), 64'd1);

        // Reset mid data word and mid TX word, then a fresh packet.
        st = 0;
        rx_send(8'h00, st);
        for (int k = 0; k < 4; k++) rx_send(8'(8'h40 + k), st);
        tx_load(64'h0011223344556677);
        base = tx_pops;
        t = 0;
        forever begin
            @(negedge clk);
            if (tx_pops - base >= 3 || t > 100) break;
            t++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        cmd_q.delete();
        word_q.delete();
        tx_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sync();
        w = 64'hA5A55A5AC3C33C3C;
        word_q.push_back(w);
        rx_send(8'h00, st);
        send_word(w, st);
        tx_load(64'h8877665544332211);
        drain("t6");
        chk("t6_err_cleared", 64'(bus.err_badHeader), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
